// File: rtl/load_store_unit_pkg.sv
// Shared load/store unit types: data and address words, and the burst write FSM encoding.
package load_store_unit_pkg;

  typedef logic [31:0] data_word_t;
  typedef logic [31:0] full_address_t;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    STREAM,
    WAIT_RESPONSE
  } burst_write_state_t;

  localparam int unsigned WORD_BYTES = 4;

  function automatic full_address_t word_align(full_address_t a);
    return a & ~full_address_t'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/burst_write_controller_if.sv
// External memory write port: address phase (request), data phase (beats) and write response.
interface burst_write_controller_if #(
  parameter int unsigned MAX_BURST = 16
) ();
  import load_store_unit_pkg::*;

  localparam int unsigned LEN_W = $clog2(MAX_BURST);

  logic              request_o;
  logic              request_ready_i;
  full_address_t     address_o;
  logic [LEN_W-1:0]  burst_length_o;
  data_word_t        data_o;
  logic              data_valid_o;
  logic              data_ready_i;
  logic              last_o;
  logic              response_i;

  modport master (
    output request_o,
    input  request_ready_i,
    output address_o,
    output burst_length_o,
    output data_o,
    output data_valid_o,
    input  data_ready_i,
    output last_o,
    input  response_i
  );

  modport slave (
    input  request_o,
    output request_ready_i,
    input  address_o,
    input  burst_length_o,
    input  data_o,
    input  data_valid_o,
    output data_ready_i,
    input  last_o,
    output response_i
  );

endinterface

// File: rtl/burst_write_controller.sv
// Drains validated words from the store burst buffer and writes them to external memory
// as request + data-beat bursts, advancing a word-aligned address pointer per burst.
module burst_write_controller
  import load_store_unit_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH = 1024,
  parameter int unsigned MAX_BURST    = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            flush_i,
  input  logic [$clog2(BUFFER_DEPTH)-1:0] buffer_size_i,
  input  logic                            buffer_valid_i,
  input  data_word_t                      buffer_data_i,
  output logic                            buffer_pull_o,
  input  logic                            address_load_i,
  input  full_address_t                   address_i,
  output logic                            busy_o,
  burst_write_controller_if.master        mem_if
);

  localparam int unsigned LEN_W = $clog2(MAX_BURST);
  localparam int unsigned CNT_W = LEN_W + 1;

  burst_write_state_t state_q, state_d;
  full_address_t      ptr_q, ptr_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   pulled_q, pulled_d;
  logic [CNT_W-1:0]   accepted_q, accepted_d;
  logic               pending_q, pending_d;

  logic [CNT_W-1:0]   launch_len;
  logic               pull;
  logic               beat_accept;
  logic               last_beat;

  always_comb begin
    if (32'(buffer_size_i) >= MAX_BURST) begin
      launch_len = CNT_W'(MAX_BURST);
    end else begin
      launch_len = CNT_W'(buffer_size_i);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    pulled_d   = pulled_q;
    accepted_d = accepted_q;
    pending_d  = pending_q;

    pull        = 1'b0;
    beat_accept = 1'b0;
    last_beat   = 1'b0;

    mem_if.request_o      = 1'b0;
    mem_if.address_o      = '0;
    mem_if.burst_length_o = '0;
    mem_if.data_o         = '0;
    mem_if.data_valid_o   = 1'b0;
    mem_if.last_o         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A pointer load takes the cycle; any launch waits for the next one.
        if (address_load_i) begin
          ptr_d = word_align(address_i);
        end else if (buffer_valid_i && (buffer_size_i != '0)) begin
          len_d      = launch_len;
          pulled_d   = '0;
          accepted_d = '0;
          pending_d  = 1'b0;
          state_d    = REQUEST;
        end
      end

      REQUEST: begin
        mem_if.request_o      = 1'b1;
        mem_if.address_o      = ptr_q;
        mem_if.burst_length_o = LEN_W'(len_q - 1'b1);
        if (mem_if.request_ready_i) begin
          state_d = STREAM;
        end
      end

      STREAM: begin
        // One word in flight: the pulled word sits on buffer_data_i until accepted.
        pull        = (pulled_q < len_q) && (!pending_q || mem_if.data_ready_i);
        beat_accept = pending_q && mem_if.data_ready_i;
        last_beat   = pending_q && (accepted_q == len_q - 1'b1);

        mem_if.data_valid_o = pending_q;
        mem_if.data_o       = pending_q ? buffer_data_i : '0;
        mem_if.last_o       = last_beat;

        if (pull) begin
          pulled_d = pulled_q + 1'b1;
        end
        if (beat_accept) begin
          accepted_d = accepted_q + 1'b1;
        end
        if (pull) begin
          pending_d = 1'b1;
        end else if (mem_if.data_ready_i) begin
          pending_d = 1'b0;
        end

        if (beat_accept && last_beat) begin
          ptr_d      = ptr_q + (32'(len_q) << 2);
          pulled_d   = '0;
          accepted_d = '0;
          state_d    = WAIT_RESPONSE;
        end
      end

      WAIT_RESPONSE: begin
        if (mem_if.response_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush_i) begin
      state_d    = IDLE;
      ptr_d      = ptr_q;
      pulled_d   = '0;
      accepted_d = '0;
      pending_d  = 1'b0;
      pull       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      pulled_q   <= '0;
      accepted_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      pulled_q   <= pulled_d;
      accepted_q <= accepted_d;
      pending_q  <= pending_d;
    end
  end

  assign buffer_pull_o = pull;
  assign busy_o        = (state_q != IDLE);

endmodule
